// File: rtl/mpa_operand_stream_sequencer.sv
// Operand stream sequencer for the arithmetic core units.
// After a start it sends a two-beat control header, then streams limbs of
// operands A and B from two synchronous limb RAMs. At the same time it checks
// the unit's result stream against an expected-result RAM and reports
// pass/fail, a saturating error count and a timeout flag.
module mpa_operand_stream_sequencer #(
  parameter int G_DATA_WIDTH = 64,
  parameter int G_ADDR_WIDTH = 9,
  parameter int G_CTRL_WIDTH = 8,
  parameter int G_ID         = 3,
  parameter int G_DRAIN      = 10,
  parameter int G_TIMEOUT    = 4096,
  parameter int G_ERR_WIDTH  = 16
) (
  input  logic                    pi_clk,
  input  logic                    pi_rst,
  input  logic                    pi_start,
  input  logic [G_CTRL_WIDTH-1:0] pi_ch_A,
  input  logic [G_CTRL_WIDTH-1:0] pi_ch_B,
  input  logic [G_ADDR_WIDTH-1:0] pi_a_last_idx,
  input  logic [G_ADDR_WIDTH-1:0] pi_b_last_idx,
  input  logic [G_ADDR_WIDTH-1:0] pi_exp_last_idx,
  output logic [G_ADDR_WIDTH-1:0] po_a_addr,
  output logic [G_ADDR_WIDTH-1:0] po_b_addr,
  input  logic [G_DATA_WIDTH-1:0] pi_a_data,
  input  logic [G_DATA_WIDTH-1:0] pi_b_data,
  output logic [G_ADDR_WIDTH-1:0] po_exp_addr,
  input  logic [G_DATA_WIDTH-1:0] pi_exp_data,
  output logic [G_CTRL_WIDTH-1:0] po_ctrl_ch_A,
  output logic [G_CTRL_WIDTH-1:0] po_ctrl_ch_B,
  output logic                    po_ctrl_valid_n,
  output logic [G_DATA_WIDTH-1:0] po_data_A,
  output logic [G_DATA_WIDTH-1:0] po_data_B,
  output logic                    po_data_last,
  output logic                    po_data_wr_en,
  output logic                    po_data_cycle,
  input  logic [G_DATA_WIDTH-1:0] pi_res_data,
  input  logic                    pi_res_last,
  input  logic                    pi_res_wr_en,
  output logic                    po_busy,
  output logic                    po_done,
  output logic                    po_ok,
  output logic [G_ERR_WIDTH-1:0]  po_err_cnt,
  output logic                    po_timeout
);

  localparam int TMO_W = $clog2(G_TIMEOUT + 1);
  localparam int DRN_W = $clog2(G_DRAIN + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR2,
    ST_PREFETCH,
    ST_FEED,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t state_q, state_d;

  // Run configuration captured when a start is accepted.
  logic [G_CTRL_WIDTH-1:0] ch_a_q, ch_a_d;
  logic [G_CTRL_WIDTH-1:0] ch_b_q, ch_b_d;
  logic [G_ADDR_WIDTH-1:0] a_last_q, a_last_d;
  logic [G_ADDR_WIDTH-1:0] b_last_q, b_last_d;
  logic [G_ADDR_WIDTH-1:0] exp_last_q, exp_last_d;
  logic [G_ADDR_WIDTH-1:0] len_last_q, len_last_d;

  // Feed-side registers. Every control output is a flop.
  logic [G_ADDR_WIDTH-1:0] feed_idx_q, feed_idx_d;
  logic [G_ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [G_ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
  logic                    wr_en_q, wr_en_d;
  logic                    cycle_q, cycle_d;
  logic                    last_q, last_d;
  logic [G_CTRL_WIDTH-1:0] ctrl_a_q, ctrl_a_d;
  logic [G_CTRL_WIDTH-1:0] ctrl_b_q, ctrl_b_d;
  logic                    valid_n_q, valid_n_d;

  // Result-check and status registers.
  logic [G_ADDR_WIDTH-1:0] res_idx_q, res_idx_d;
  logic                    exp_seen_q, exp_seen_d;
  logic                    res_done_q, res_done_d;
  logic [G_ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic                    ok_q, ok_d;
  logic                    timeout_q, timeout_d;
  logic                    done_q, done_d;
  logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;

  logic check_active;
  logic res_beat;
  logic exp_is_last;
  logic res_mismatch;

  // Step an address forward by one limb, but stop at that operand's last limb.
  function automatic logic [G_ADDR_WIDTH-1:0] sat_inc(
    input logic [G_ADDR_WIDTH-1:0] cur,
    input logic [G_ADDR_WIDTH-1:0] lim
  );
    sat_inc = (cur < lim) ? cur + 1'b1 : cur;
  endfunction

  // Classify the incoming result beat against the expected limb at the current index.
  // A beat in DRAIN is always an error, because the unit has already sent its last beat.
  always_comb begin
    check_active = (state_q == ST_FEED) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    res_beat     = check_active && pi_res_wr_en;
    exp_is_last  = (res_idx_q == exp_last_q);
    res_mismatch = (pi_res_data != pi_exp_data) ||
                   (pi_res_last != exp_is_last) ||
                   exp_seen_q ||
                   (state_q == ST_DRAIN);
  end

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered, so each registered control lines up with its state.
  always_comb begin
    state_d     = state_q;
    ch_a_d      = ch_a_q;
    ch_b_d      = ch_b_q;
    a_last_d    = a_last_q;
    b_last_d    = b_last_q;
    exp_last_d  = exp_last_q;
    len_last_d  = len_last_q;
    feed_idx_d  = feed_idx_q;
    a_addr_d    = '0;
    b_addr_d    = '0;
    wr_en_d     = 1'b0;
    cycle_d     = 1'b0;
    last_d      = 1'b0;
    ctrl_a_d    = '0;
    ctrl_b_d    = '0;
    valid_n_d   = 1'b1;
    res_idx_d   = res_idx_q;
    exp_seen_d  = exp_seen_q;
    res_done_d  = res_done_q;
    err_cnt_d   = err_cnt_q;
    ok_d        = ok_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    drain_cnt_d = drain_cnt_q;

    if (res_beat) begin
      if (res_mismatch) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        ok_d = 1'b0;
      end
      res_idx_d = sat_inc(res_idx_q, exp_last_q);
      if (exp_is_last) begin
        exp_seen_d = 1'b1;
      end
      if (pi_res_last) begin
        res_done_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pi_start) begin
          ch_a_d      = pi_ch_A;
          ch_b_d      = pi_ch_B;
          a_last_d    = pi_a_last_idx;
          b_last_d    = pi_b_last_idx;
          exp_last_d  = pi_exp_last_idx;
          len_last_d  = (pi_a_last_idx > pi_b_last_idx) ? pi_a_last_idx : pi_b_last_idx;
          res_idx_d   = '0;
          exp_seen_d  = 1'b0;
          res_done_d  = 1'b0;
          err_cnt_d   = '0;
          ok_d        = 1'b1;
          timeout_d   = 1'b0;
          ctrl_a_d    = G_CTRL_WIDTH'(G_ID);
          ctrl_b_d    = G_CTRL_WIDTH'(G_ID);
          valid_n_d   = 1'b0;
          state_d     = ST_HDR1;
        end
      end
      ST_HDR1: begin
        ctrl_a_d = ch_a_q;
        ctrl_b_d = ch_b_q;
        state_d  = ST_HDR2;
      end
      ST_HDR2: begin
        state_d = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        feed_idx_d = '0;
        a_addr_d   = sat_inc(a_addr_q, a_last_q);
        b_addr_d   = sat_inc(b_addr_q, b_last_q);
        wr_en_d    = 1'b1;
        cycle_d    = 1'b1;
        last_d     = (len_last_q == '0);
        state_d    = ST_FEED;
      end
      ST_FEED: begin
        if (feed_idx_q == len_last_q) begin
          tmo_cnt_d = '0;
          state_d   = ST_WAIT;
        end else begin
          feed_idx_d = feed_idx_q + 1'b1;
          a_addr_d   = sat_inc(a_addr_q, a_last_q);
          b_addr_d   = sat_inc(b_addr_q, b_last_q);
          wr_en_d    = 1'b1;
          last_d     = ((feed_idx_q + 1'b1) == len_last_q);
        end
      end
      ST_WAIT: begin
        if ((res_beat && pi_res_last) || res_done_q) begin
          drain_cnt_d = '0;
          state_d     = ST_DRAIN;
        end else if (res_beat) begin
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_W'(G_TIMEOUT - 1)) begin
          timeout_d   = 1'b1;
          ok_d        = 1'b0;
          drain_cnt_d = '0;
          state_d     = ST_DRAIN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRN_W'(G_DRAIN - 1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; a reset abandons any run.
  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state_q     <= ST_IDLE;
      ch_a_q      <= '0;
      ch_b_q      <= '0;
      a_last_q    <= '0;
      b_last_q    <= '0;
      exp_last_q  <= '0;
      len_last_q  <= '0;
      feed_idx_q  <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      wr_en_q     <= 1'b0;
      cycle_q     <= 1'b0;
      last_q      <= 1'b0;
      ctrl_a_q    <= '0;
      ctrl_b_q    <= '0;
      valid_n_q   <= 1'b1;
      res_idx_q   <= '0;
      exp_seen_q  <= 1'b0;
      res_done_q  <= 1'b0;
      err_cnt_q   <= '0;
      ok_q        <= 1'b1;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      tmo_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_a_q      <= ch_a_d;
      ch_b_q      <= ch_b_d;
      a_last_q    <= a_last_d;
      b_last_q    <= b_last_d;
      exp_last_q  <= exp_last_d;
      len_last_q  <= len_last_d;
      feed_idx_q  <= feed_idx_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      wr_en_q     <= wr_en_d;
      cycle_q     <= cycle_d;
      last_q      <= last_d;
      ctrl_a_q    <= ctrl_a_d;
      ctrl_b_q    <= ctrl_b_d;
      valid_n_q   <= valid_n_d;
      res_idx_q   <= res_idx_d;
      exp_seen_q  <= exp_seen_d;
      res_done_q  <= res_done_d;
      err_cnt_q   <= err_cnt_d;
      ok_q        <= ok_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Operand data passes straight from the limb RAMs. The shorter operand is
  // zero-padded, and the data bus is quiet outside FEED.
  always_comb begin
    po_data_A = '0;
    po_data_B = '0;
    if (state_q == ST_FEED) begin
      if (feed_idx_q <= a_last_q) begin
        po_data_A = pi_a_data;
      end
      if (feed_idx_q <= b_last_q) begin
        po_data_B = pi_b_data;
      end
    end
  end

  assign po_a_addr       = a_addr_q;
  assign po_b_addr       = b_addr_q;
  assign po_exp_addr     = res_idx_q;
  assign po_ctrl_ch_A    = ctrl_a_q;
  assign po_ctrl_ch_B    = ctrl_b_q;
  assign po_ctrl_valid_n = valid_n_q;
  assign po_data_last    = last_q;
  assign po_data_wr_en   = wr_en_q;
  assign po_data_cycle   = cycle_q;
  assign po_busy         = (state_q != ST_IDLE);
  assign po_done         = done_q;
  assign po_ok           = ok_q;
  assign po_err_cnt      = err_cnt_q;
  assign po_timeout      = timeout_q;

endmodule

// File: tb/tb_mpa_operand_stream_sequencer.sv
// Self-checking bench for mpa_operand_stream_sequencer.
// It models the limb RAMs, the expected RAM and the core unit's result stream.
// Expected feed beats go into a scoreboard queue and are compared as the DUT
// emits them. Each run comes from a table of records.
module tb_mpa_operand_stream_sequencer;

  localparam int TMO   = 16;
  localparam int DRAIN = 10;
  localparam int ID    = 3;

  typedef struct {
    int a_last;
    int b_last;
    int exp_last;
    int corrupt;
    int n_beats;
    int extra;
    bit busy_start;
    bit exp_ok;
    int exp_err;
    bit exp_tmo;
  } vec_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cyc;
    logic        last;
    logic [8:0]  a_addr;
    logic [8:0]  b_addr;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  ch_a, ch_b;
  logic [8:0]  a_last_idx, b_last_idx, exp_last_idx;
  logic [8:0]  a_addr, b_addr, exp_addr;
  logic [63:0] a_rdata, b_rdata, exp_data;
  logic [7:0]  ctrl_a, ctrl_b;
  logic        ctrl_valid_n;
  logic [63:0] data_a, data_b;
  logic        data_last, data_wr_en, data_cycle;
  logic [63:0] res_data;
  logic        res_last, res_wr_en;
  logic        busy, done, ok, tmo;
  logic [15:0] err_cnt;

  logic [63:0] mem_a   [0:511];
  logic [63:0] mem_b   [0:511];
  logic [63:0] mem_exp [0:511];
  logic [63:0] res_ref [0:511];

  beat_t fb_q[$];
  beat_t mon_b;
  vec_t  vecs[7];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_feed_cyc = 0;
  int last_res_cyc  = 0;

  mpa_operand_stream_sequencer #(
    .G_DATA_WIDTH(64),
    .G_ADDR_WIDTH(9),
    .G_CTRL_WIDTH(8),
    .G_ID(ID),
    .G_DRAIN(DRAIN),
    .G_TIMEOUT(TMO),
    .G_ERR_WIDTH(16)
  ) dut (
    .pi_clk(clk),
    .pi_rst(rst),
    .pi_start(start),
    .pi_ch_A(ch_a),
    .pi_ch_B(ch_b),
    .pi_a_last_idx(a_last_idx),
    .pi_b_last_idx(b_last_idx),
    .pi_exp_last_idx(exp_last_idx),
    .po_a_addr(a_addr),
    .po_b_addr(b_addr),
    .pi_a_data(a_rdata),
    .pi_b_data(b_rdata),
    .po_exp_addr(exp_addr),
    .pi_exp_data(exp_data),
    .po_ctrl_ch_A(ctrl_a),
    .po_ctrl_ch_B(ctrl_b),
    .po_ctrl_valid_n(ctrl_valid_n),
    .po_data_A(data_a),
    .po_data_B(data_b),
    .po_data_last(data_last),
    .po_data_wr_en(data_wr_en),
    .po_data_cycle(data_cycle),
    .pi_res_data(res_data),
    .pi_res_last(res_last),
    .pi_res_wr_en(res_wr_en),
    .po_busy(busy),
    .po_done(done),
    .po_ok(ok),
    .po_err_cnt(err_cnt),
    .po_timeout(tmo)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Limb RAMs have a one-cycle read latency; the expected RAM is read asynchronously.
  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
  end

  assign exp_data = mem_exp[exp_addr];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: bounded wait expired", name);
  endtask

  // Scoreboard consumer: each feed beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (data_wr_en) begin
      if (fb_q.size() == 0) begin
        reportFail("unexpected_feed_beat");
      end else begin
        mon_b = fb_q.pop_front();
        checkOutput("feed_data_A", data_a, mon_b.a);
        checkOutput("feed_data_B", data_b, mon_b.b);
        checkOutput("feed_cycle", {63'd0, data_cycle}, {63'd0, mon_b.cyc});
        checkOutput("feed_last", {63'd0, data_last}, {63'd0, mon_b.last});
        checkOutput("feed_a_addr", {55'd0, a_addr}, {55'd0, mon_b.a_addr});
        checkOutput("feed_b_addr", {55'd0, b_addr}, {55'd0, mon_b.b_addr});
        if (mon_b.last) begin
          last_feed_cyc = cyc;
        end
      end
    end
  end

  task automatic pushFeed(input int a_l, input int b_l);
    int l = (a_l > b_l) ? a_l : b_l;
    beat_t b;
    for (int k = 0; k <= l; k++) begin
      b.a      = (k <= a_l) ? mem_a[k] : 64'd0;
      b.b      = (k <= b_l) ? mem_b[k] : 64'd0;
      b.cyc    = (k == 0);
      b.last   = (k == l);
      b.a_addr = 9'(((k + 1) > a_l) ? a_l : k + 1);
      b.b_addr = 9'(((k + 1) > b_l) ? b_l : k + 1);
      fb_q.push_back(b);
    end
  endtask

  // Pulse start and check the header beats and the prefetch cycle. Entered on a negedge.
  task automatic startRun(input int a_l, input int b_l, input int e_l, input logic [7:0] ca, input logic [7:0] cb);
    a_last_idx   = 9'(a_l);
    b_last_idx   = 9'(b_l);
    exp_last_idx = 9'(e_l);
    ch_a         = ca;
    ch_b         = cb;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("hdr1_ch_A", {56'd0, ctrl_a}, 64'(ID));
    checkOutput("hdr1_ch_B", {56'd0, ctrl_b}, 64'(ID));
    checkOutput("hdr1_valid_n", {63'd0, ctrl_valid_n}, 64'd0);
    checkOutput("hdr1_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    checkOutput("hdr2_ch_A", {56'd0, ctrl_a}, {56'd0, ca});
    checkOutput("hdr2_ch_B", {56'd0, ctrl_b}, {56'd0, cb});
    checkOutput("hdr2_valid_n", {63'd0, ctrl_valid_n}, 64'd1);
    @(negedge clk);
    checkOutput("pref_ch_A", {56'd0, ctrl_a}, 64'd0);
    checkOutput("pref_a_addr", {55'd0, a_addr}, 64'd0);
    checkOutput("pref_b_addr", {55'd0, b_addr}, 64'd0);
    checkOutput("pref_wr_en", {63'd0, data_wr_en}, 64'd0);
  endtask

  // Run one table record end to end: header, feed, result stream, drain, status.
  task automatic applyStimulus(input vec_t v, input int row);
    bit seen;
    int done_cyc;
    for (int i = 0; i < 512; i++) begin
      mem_exp[i] = res_ref[i];
    end
    if (v.corrupt >= 0) begin
      mem_exp[v.corrupt][0] = ~mem_exp[v.corrupt][0];
    end
    pushFeed(v.a_last, v.b_last);
    startRun(v.a_last, v.b_last, v.exp_last, 8'(16 + row), 8'(200 - row));
    for (int i = 0; i < 1200 && fb_q.size() != 0; i++) begin
      @(negedge clk);
    end
    if (fb_q.size() != 0) begin
      reportFail("feed_complete");
      fb_q.delete();
    end
    @(negedge clk);
    if (v.busy_start) begin
      start        = 1'b1;
      a_last_idx   = 9'd0;
      exp_last_idx = 9'd0;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_start_valid_n", {63'd0, ctrl_valid_n}, 64'd1);
      checkOutput("busy_start_ctrl_A", {56'd0, ctrl_a}, 64'd0);
      checkOutput("busy_start_busy", {63'd0, busy}, 64'd1);
    end
    for (int i = 0; i < v.n_beats; i++) begin
      res_wr_en = 1'b1;
      res_data  = res_ref[i];
      res_last  = (i == v.n_beats - 1);
      if (i == v.n_beats - 1) begin
        last_res_cyc = cyc;
      end
      @(negedge clk);
    end
    for (int i = 0; i < v.extra; i++) begin
      res_wr_en = 1'b1;
      res_data  = 64'hDEAD_BEEF_0000_0000 + 64'(i);
      res_last  = 1'b0;
      @(negedge clk);
    end
    res_wr_en = 1'b0;
    res_last  = 1'b0;
    seen      = 1'b0;
    done_cyc  = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen     = 1'b1;
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      reportFail("done_seen");
    end else begin
      checkOutput("status_ok", {63'd0, ok}, {63'd0, v.exp_ok});
      checkOutput("status_err_cnt", {48'd0, err_cnt}, 64'(v.exp_err));
      checkOutput("status_timeout", {63'd0, tmo}, {63'd0, v.exp_tmo});
      checkOutput("done_busy", {63'd0, busy}, 64'd0);
      if (v.n_beats > 0) begin
        checkOutput("drain_latency", 64'(done_cyc - last_res_cyc), 64'(DRAIN + 1));
      end else begin
        checkOutput("timeout_latency", 64'(done_cyc - last_feed_cyc), 64'(1 + TMO + DRAIN));
      end
      @(negedge clk);
      checkOutput("done_pulse_width", {63'd0, done}, 64'd0);
      checkOutput("status_hold_err_cnt", {48'd0, err_cnt}, 64'(v.exp_err));
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, "_valid_n"}, {63'd0, ctrl_valid_n}, 64'd1);
    checkOutput({tag, "_ok"}, {63'd0, ok}, 64'd1);
    checkOutput({tag, "_err_cnt"}, {48'd0, err_cnt}, 64'd0);
    checkOutput({tag, "_timeout"}, {63'd0, tmo}, 64'd0);
    checkOutput({tag, "_wr_en"}, {63'd0, data_wr_en}, 64'd0);
    checkOutput({tag, "_a_addr"}, {55'd0, a_addr}, 64'd0);
    checkOutput({tag, "_data_A"}, data_a, 64'd0);
    checkOutput({tag, "_done"}, {63'd0, done}, 64'd0);
    checkOutput({tag, "_ctrl_A"}, {56'd0, ctrl_a}, 64'd0);
  endtask

  // Main sequence: table runs, then reset in the middle of FEED, then a recovery run.
  initial begin
    vecs[0] = '{0, 0, 1, -1, 2, 0, 1'b0, 1'b1, 0, 1'b0};
    vecs[1] = '{4, 1, 3, -1, 4, 0, 1'b0, 1'b1, 0, 1'b0};
    vecs[2] = '{1, 6, 2, -1, 3, 0, 1'b0, 1'b1, 0, 1'b0};
    vecs[3] = '{2, 2, 5, 3, 6, 0, 1'b0, 1'b0, 1, 1'b0};
    vecs[4] = '{0, 0, 0, -1, 0, 0, 1'b0, 1'b0, 0, 1'b1};
    vecs[5] = '{1, 3, 5, -1, 3, 1, 1'b0, 1'b0, 2, 1'b0};
    vecs[6] = '{2, 2, 2, -1, 3, 0, 1'b1, 1'b1, 0, 1'b0};

    for (int i = 0; i < 512; i++) begin
      mem_a[i]   = {$urandom, $urandom} | 64'd1;
      mem_b[i]   = {$urandom, $urandom} | 64'd1;
      res_ref[i] = {$urandom, $urandom};
      mem_exp[i] = res_ref[i];
    end

    rst          = 1'b1;
    start        = 1'b0;
    ch_a         = 8'd0;
    ch_b         = 8'd0;
    a_last_idx   = 9'd0;
    b_last_idx   = 9'd0;
    exp_last_idx = 9'd0;
    res_data     = 64'd0;
    res_last     = 1'b0;
    res_wr_en    = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      $display("[TB] run %0d", r);
      applyStimulus(vecs[r], r);
    end

    $display("[TB] reset during FEED");
    for (int i = 0; i < 512; i++) begin
      mem_exp[i] = res_ref[i];
    end
    pushFeed(10, 10);
    startRun(10, 10, 3, 8'h5A, 8'hA5);
    for (int i = 0; i < 100 && fb_q.size() > 8; i++) begin
      @(negedge clk);
    end
    if (fb_q.size() > 8) begin
      reportFail("feed_started");
    end
    res_wr_en = 1'b1;
    res_data  = ~res_ref[0];
    res_last  = 1'b0;
    @(negedge clk);
    res_wr_en = 1'b0;
    checkOutput("feed_overlap_err_cnt", {48'd0, err_cnt}, 64'd1);
    checkOutput("feed_overlap_ok", {63'd0, ok}, 64'd0);
    checkOutput("feed_still_running", {63'd0, data_wr_en}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetValues("midrun_reset");
    fb_q.delete();
    @(negedge clk);

    $display("[TB] recovery run with start while busy");
    applyStimulus(vecs[6], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mpa_operand_stream_sequencer.md
Name: mpa_operand_stream_sequencer

Overview:
Synthesizable, parametrised successor of the bench-side operand feeder/checker used around the core arithmetic units; it can run on-chip in regression builds.
- On start, issues the two-beat control header to a core unit, then streams operands A and B as 64-bit limb streams from two limb RAMs.
- Collects the unit's result stream and checks it beat-by-beat against an expected-result RAM.
- Reports pass/fail, error count and timeout, so multiplier/adder units can be soak-tested without a simulator.

Parameters:
G_DATA_WIDTH, 64, limb width.
G_ADDR_WIDTH, 9, limb index width; operand/result length 1..2^G_ADDR_WIDTH limbs.
G_CTRL_WIDTH, 8, control channel width.
G_ID, 3, unit id sent in header beat 1.
G_DRAIN, 10, idle cycles after result last before done.
G_TIMEOUT, 4096, max cycles in WAIT without a result beat before abort.
G_ERR_WIDTH, 16, error counter width (saturating).

Ports:
pi_clk  in  1  clock
pi_rst  in  1  synchronous reset, active-high
pi_start  in  1  start pulse, accepted in IDLE only
pi_ch_A  in  G_CTRL_WIDTH  source channel select for A (header beat 2)
pi_ch_B  in  G_CTRL_WIDTH  source channel select for B (header beat 2)
pi_a_last_idx  in  G_ADDR_WIDTH  index of A's last limb (prec-1)
pi_b_last_idx  in  G_ADDR_WIDTH  index of B's last limb
pi_exp_last_idx  in  G_ADDR_WIDTH  index of expected result's last limb
po_a_addr / po_b_addr  out  G_ADDR_WIDTH  limb RAM read addresses (sync RAM, 1-cycle latency)
pi_a_data / pi_b_data  in  G_DATA_WIDTH  limb RAM read data
po_exp_addr  out  G_ADDR_WIDTH  expected RAM address (async read)
pi_exp_data  in  G_DATA_WIDTH  expected limb
po_ctrl_ch_A / po_ctrl_ch_B  out  G_CTRL_WIDTH  control channels
po_ctrl_valid_n  out  1  header-valid, active-low
po_data_A / po_data_B  out  G_DATA_WIDTH  operand limbs
po_data_last  out  1  final feed beat
po_data_wr_en  out  1  feed beat valid
po_data_cycle  out  1  first feed beat marker
pi_res_data  in  G_DATA_WIDTH  result limb
pi_res_last  in  1  result last
pi_res_wr_en  in  1  result beat valid
po_busy  out  1  not IDLE
po_done  out  1  one-cycle completion pulse
po_ok  out  1  last run passed
po_err_cnt  out  G_ERR_WIDTH  mismatches in last run
po_timeout  out  1  last run aborted by timeout

Behaviour:
- Reset values: all outputs 0, except po_ctrl_valid_n=1 and po_ok=1. State=IDLE.
- FSM: IDLE -> HDR1 -> HDR2 -> PREFETCH -> FEED -> WAIT -> DRAIN -> IDLE.
- IDLE, pi_start=1: latch all pi_* config into registers; clear err_cnt, timeout and result index; set ok=1.
- HDR1 (1 cycle): ctrl_A=ctrl_B=G_ID, valid_n=0.
- HDR2 (1 cycle): ctrl_A=latched ch_A, ctrl_B=latched ch_B, valid_n=1.
- Outside HDR1/HDR2: ctrl outputs=0, valid_n=1.
- PREFETCH (1 cycle): a_addr=b_addr=0.
- FEED: on each cycle k=0..L, with L=max(a_last_idx, b_last_idx):
  - addresses for limb k+1 are issued (saturating at their last index); wr_en=1.
  - po_data_A = pi_a_data when k<=a_last_idx, else 0 (zero-pads the shorter operand). Same rule for B.
  - data_cycle=1 at k=0 only; data_last=1 at k=L only.
  - Data outputs are combinational from RAM data; all controls are registered.
  - L+1 beats total, then -> WAIT.
- Result check runs in FEED, WAIT and DRAIN (results may overlap feeding):
  - po_exp_addr = result index.
  - On pi_res_wr_en, mismatch if pi_res_data != pi_exp_data, or pi_res_last != (index==exp_last_idx), or the beat arrives after exp last was already seen.
  - Mismatch: err_cnt+1 (saturating at all-ones), ok=0.
  - Index increments, saturating at exp_last_idx.
- WAIT:
  - -> DRAIN on a result beat with res_last.
  - Timeout counter resets on every result beat. Reaching G_TIMEOUT -> timeout=1, ok=0, -> DRAIN.
- DRAIN: G_DRAIN cycles. Any result beat here is counted as an error. Then done=1 for one cycle -> IDLE.
- pi_start while busy: ignored.
- pi_rst mid-run: immediate return to reset values; in-flight stream is abandoned.
- Status (ok, err_cnt, timeout) holds until the next accepted start.

Test Plan:
- A=B=1 limb (idx 0), exp 2 limbs correct -> header beats (3,3, valid_n=0) then (chA,chB, valid_n=1); single feed beat with wr_en, cycle and last all 1; done, ok=1, err_cnt=0.
- a_last_idx=4, b_last_idx=1 -> 5 feed beats; po_data_B=0 on beats 2..4; last only on beat 4.
- Expected limb 3 corrupted (bit 0 flipped), exp 6 limbs -> err_cnt=1, ok=0, done after drain.
- Result last arrives at index 2 with exp_last_idx=5 -> last-flag mismatch counted; an extra beat in DRAIN adds another error.
- No result beats, G_TIMEOUT=16 -> timeout=1, ok=0, done 16+G_DRAIN cycles after WAIT entry.
- pi_rst asserted mid-FEED, then new start -> outputs at reset values the next cycle; second run completes with ok=1; start pulse during busy has no effect.
